// File: rtl/pipe_sink.sv
// pipe_sink: FWFT receiver for the dual-lane stall pipeline with lane-equality check and registered back-pressure.
// Optional embedded assertions/assumption enabled by defining PIPE_SINK_ASSERT_EN.
module pipe_sink #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_d1,
  input  logic [W-1:0]               in_d2,
  output logic                       stall,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       mismatch,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;
  logic          mismatch_q, mismatch_d;
  logic          overflow_q, overflow_d;
  logic          pop_s, push_s;

  // Handshake decode, occupancy and sticky-flag next state
  always_comb begin
    pop_s      = 1'b0;
    push_s     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    stall_d    = stall_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;

    pop_s  = (count_q != {CW{1'b0}}) & out_ready;
    push_s = in_valid & ((count_q < CW'(DEPTH)) | pop_s);

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    // Threshold leaves SKID free slots for beats launched before upstream sees stall
    stall_d = (count_d >= CW'(DEPTH - SKID));

    mismatch_d = mismatch_q | (push_s & (in_d1 != in_d2));
    overflow_d = overflow_q | (in_valid & (count_q == CW'(DEPTH)) & ~pop_s);
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      stall_q    <= 1'b0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end

  // Lane-1 storage; contents are meaningless while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_d1;
    end
  end

  assign stall     = stall_q;
  assign count     = count_q;
  assign mismatch  = mismatch_q;
  assign overflow  = overflow_q;
  assign out_valid = (count_q != {CW{1'b0}});
  assign out_data  = mem_q[rd_ptr_q];

`ifdef PIPE_SINK_ASSERT_EN
  logic [CW-1:0] skid_beats_q;

  // Beats received while stalled; bounded by SKID when upstream honours stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_beats_q <= {CW{1'b0}};
    end else if (stall_q & in_valid) begin
      if (skid_beats_q < CW'(DEPTH)) begin
        skid_beats_q <= skid_beats_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        skid_beats_q <= skid_beats_q;
      end
    end else begin
      skid_beats_q <= {CW{1'b0}};
    end
  end

  // Embedded interface and consistency checks
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_ovf: assert (!(in_valid & (count_q == CW'(DEPTH)) & ~pop_s));
      a_lanes:  assert (!(in_valid & (in_d1 != in_d2)));
      a_cnt:    assert (count_q <= CW'(DEPTH));
      a_stall:  assert (stall_q == (count_q >= CW'(DEPTH - SKID)));
      m_skid:   assume (skid_beats_q <= CW'(SKID));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sink.sv
// Self-checking bench for pipe_sink: scoreboard queue for the output stream plus directed status checks.
module tb_pipe_sink;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_d1 = '0;
  logic [W-1:0]  in_d2 = '0;
  logic          stall;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          mismatch;
  logic          overflow;

  int nvec = 0;
  int nerr = 0;
  logic [W-1:0] exp_q [$];

  pipe_sink #(.W(W), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_d1(in_d1), .in_d2(in_d2),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .mismatch(mismatch), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d1, input logic [W-1:0] d2);
    in_valid = 1'b1;
    in_d1 = d1;
    in_d2 = d2;
    exp_q.push_back(d1);
    cyc();
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted head beat must match the scoreboard front
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL out_data: got 0x%0h, expected no beat", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          nerr++;
          $display("FAIL out_data: got 0x%0h, expected 0x%0h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: reset values, then three beats with no drain
    #1;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_overflow", overflow, 0);
    cyc();
    rst = 1'b0;
    push(16'h0011, 16'h0011);
    check("s1_valid", out_valid, 1);
    check("s1_data", out_data, 16'h0011);
    check("s1_count1", count, 1);
    check("s1_stall1", stall, 0);
    push(16'h0022, 16'h0022);
    check("s1_count2", count, 2);
    check("s1_stall2", stall, 1);
    push(16'h0033, 16'h0033);
    check("s1_count3", count, 3);
    check("s1_stall3", stall, 1);
    check("s1_mismatch", mismatch, 0);
    check("s1_head", out_data, 16'h0011);

    // Scenario 2: drain three beats
    out_ready = 1'b1;
    cyc();
    check("s2_count2", count, 2);
    check("s2_stall2", stall, 1);
    cyc();
    check("s2_count1", count, 1);
    check("s2_stall1", stall, 0);
    cyc();
    check("s2_count0", count, 0);
    check("s2_valid0", out_valid, 0);
    out_ready = 1'b0;

    // Scenario 3: push and pop together while full
    push(16'h00B1, 16'h00B1);
    push(16'h00B2, 16'h00B2);
    push(16'h00B3, 16'h00B3);
    push(16'h00B4, 16'h00B4);
    check("s3_full", count, 4);
    check("s3_stall", stall, 1);
    out_ready = 1'b1;
    push(16'h00AA, 16'h00AA);
    check("s3_count", count, 4);
    check("s3_overflow", overflow, 0);
    repeat (4) cyc();
    check("s3_drained", count, 0);
    check("s3_valid0", out_valid, 0);
    out_ready = 1'b0;

    // Scenario 4: beat arriving when full with no pop is dropped
    push(16'h00C1, 16'h00C1);
    push(16'h00C2, 16'h00C2);
    push(16'h00C3, 16'h00C3);
    push(16'h00C4, 16'h00C4);
    in_valid = 1'b1;
    in_d1 = 16'h00DD;
    in_d2 = 16'h00DD;
    cyc();
    in_valid = 1'b0;
    check("s4_overflow", overflow, 1);
    check("s4_count", count, 4);
    cyc();
    check("s4_ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    check("s4_drained", count, 0);
    check("s4_ovf_hold", overflow, 1);

    // Scenario 5: lane mismatch is flagged but lane 1 is still stored
    push(16'h1234, 16'h1235);
    check("s5_mismatch", mismatch, 1);
    check("s5_data", out_data, 16'h1234);
    cyc();
    check("s5_mm_sticky", mismatch, 1);
    push(16'h0055, 16'h0055);
    check("s5_count", count, 2);
    check("s5_stall", stall, 1);

    // Scenario 6: asynchronous reset mid-stream, away from any clock edge
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("s6_count", count, 0);
    check("s6_valid", out_valid, 0);
    check("s6_stall", stall, 0);
    check("s6_mismatch", mismatch, 0);
    check("s6_overflow", overflow, 0);
    cyc();
    rst = 1'b0;
    push(16'h0077, 16'h0077);
    check("s6_first", out_data, 16'h0077);
    out_ready = 1'b1;
    push(16'h0088, 16'h0088);
    check("s6_count1", count, 1);
    cyc();
    out_ready = 1'b0;
    check("s6_empty", out_valid, 0);
    check("s6_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
